aes_loopback_ctrl: RTL

Sequencer for an external iterative AES round datapath shared by the encrypt and decrypt directions. On start it latches a plaintext and key-size mode, then runs the encryption rounds and captures the ciphertext. It then feeds the ciphertext back through the inverse rounds and compares the result with the plaintext. It replaces the free-running round counters and combinational self-check in the board top level and drives the pass/fail LEDs and the 7-segment ciphertext byte.

---
 rtl/aes_ctrl_pkg.sv | 16 +
 rtl/aes_round_counter.sv | 23 ++
 rtl/aes_loopback_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/aes_ctrl_pkg.sv
// aes_ctrl_pkg: key-size encodings, round counts and FSM states for the AES loopback controller.
package aes_ctrl_pkg;
    localparam logic [1:0] MODE_128     = 2'b00;
    localparam logic [1:0] MODE_192     = 2'b01;
    localparam logic [1:0] MODE_256     = 2'b10;
    localparam logic [1:0] MODE_ILLEGAL = 2'b11;
    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    typedef enum logic [2:0] {S_IDLE, S_ENC, S_DEC, S_CHECK, S_DONE} state_t;

    function automatic logic [3:0] mode_to_nr(input logic [1:0] m);
        return m == MODE_192 ? NR_192 : m == MODE_256 ? NR_256 : NR_128;
    endfunction
endpackage

// File: rtl/aes_round_counter.sv
// aes_round_counter: loadable up/down round index with zero and last-round flags.
module aes_round_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         up,
    input  logic         en,
    input  logic [W-1:0] nr,
    output logic [W-1:0] count,
    output logic         is_zero,
    output logic         is_nr
);
    always_ff @(posedge clk or posedge rst)
        if (rst) count <= '0;
        else if (load) count <= load_val;
        else if (en) count <= up ? count + 1'b1 : count - 1'b1;

    assign is_zero = count == '0;
    assign is_nr   = count == nr;
endmodule

// File: rtl/aes_loopback_ctrl.sv
// aes_loopback_ctrl: runs encrypt then inverse rounds on a shared AES round datapath and self-checks.
// Define AES_CTRL_STALL_EN to add the rnd_ready round-advance handshake.
module aes_loopback_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int RND_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] pt_in,
    output logic [DATA_W-1:0] rnd_in,
    output logic [RND_W-1:0]  rnd_idx,
    output logic              rnd_inv,
    output logic              rnd_first,
    output logic              rnd_last,
    input  logic [DATA_W-1:0] rnd_out,
`ifdef AES_CTRL_STALL_EN
    input  logic              rnd_ready,
`endif
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [DATA_W-1:0] ct_out,
    output logic [7:0]        ct_byte
);
    state_t             state, state_d;
    logic [DATA_W-1:0]  state_q, pt_q, ct_q;
    logic [RND_W-1:0]   nr_q;
    logic               adv, cnt_load, cnt_up, cnt_en, is_zero, is_nr;

`ifdef AES_CTRL_STALL_EN
    assign adv = rnd_ready;
`else
    assign adv = 1'b1;
`endif

    aes_round_counter #(.W(RND_W)) u_cnt (
        .clk(clk), .rst(rst), .load(cnt_load), .load_val('0), .up(cnt_up), .en(cnt_en),
        .nr(nr_q), .count(rnd_idx), .is_zero(is_zero), .is_nr(is_nr)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= S_IDLE;
        else state <= state_d;

    always_comb begin
        state_d  = state;
        cnt_load = 1'b0;
        cnt_up   = 1'b0;
        cnt_en   = 1'b0;
        case (state)
            S_IDLE: if (start) begin
                state_d  = mode == MODE_ILLEGAL ? S_DONE : S_ENC;
                cnt_load = 1'b1;
            end
            S_ENC: if (adv) begin
                cnt_up  = 1'b1;
                cnt_en  = !is_nr;
                state_d = is_nr ? S_DEC : S_ENC;
            end
            S_DEC: if (adv) begin
                cnt_en  = !is_zero;
                state_d = is_zero ? S_CHECK : S_DEC;
            end
            S_CHECK: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= '0;
            pt_q    <= '0;
            ct_q    <= '0;
            nr_q    <= '0;
            pass    <= 1'b0;
            fail    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    pass <= 1'b0;
                    fail <= mode == MODE_ILLEGAL;
                    if (mode != MODE_ILLEGAL) begin
                        pt_q    <= pt_in;
                        state_q <= pt_in;
                        nr_q    <= RND_W'(mode_to_nr(mode));
                    end
                end
                S_ENC: if (adv) begin
                    state_q <= rnd_out;
                    if (is_nr) ct_q <= rnd_out;
                end
                S_DEC: if (adv) state_q <= rnd_out;
                S_CHECK: begin
                    pass <= state_q == pt_q;
                    fail <= state_q != pt_q;
                end
                default: ;
            endcase
        end

    // First/last flags swap meaning between directions since the inverse cipher counts down.
    assign rnd_in    = state_q;
    assign rnd_inv   = state == S_DEC;
    assign rnd_first = (state == S_ENC && is_zero) || (state == S_DEC && is_nr);
    assign rnd_last  = (state == S_ENC && is_nr) || (state == S_DEC && is_zero);
    assign busy      = state == S_ENC || state == S_DEC || state == S_CHECK;
    assign done      = state == S_DONE;
    assign ct_out    = ct_q;
    assign ct_byte   = ct_q[7:0];
endmodule
